regfile_scoreboard: RTL and testbench

Parametrised integer register file for the pipelined RISC-V core: NUM_RD asynchronous read ports, one synchronous write-back port, and a per-register pending-write scoreboard. It sits between decode/issue and write-back. Decode reads operands and busy status here. Issue reserves the destination register. Write-back commits data and releases the reservation. This lets the hazard unit stall on in-flight writes, including several outstanding writes to one register.

---
 rtl/regfile_scoreboard.sv | 103 ++++++++++
 tb/tb_regfile_scoreboard.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with combinational read ports, one write-back port and a
// per-register pending-write counter. Define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int NUM_RD = 2,
  parameter int PEND_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  output logic                     iss_ready,
  input  logic                     wb_valid,
  input  logic [AW-1:0]            wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     wb_err
);

  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1'b1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [AW-1:0]     X0        = {AW{1'b0}};
  localparam logic [XLEN-1:0]   DZERO     = {XLEN{1'b0}};

  logic [XLEN-1:0]   regs_r     [NREGS];
  logic [PEND_W-1:0] pend_r     [NREGS];
  logic [PEND_W-1:0] pend_nxt_s [NREGS];
  logic              wb_err_r;
  logic              iss_acc_s;
  logic              wb_live_s;
  logic              wb_under_s;

  assign iss_ready  = (iss_rd == X0) || (pend_r[iss_rd] != PEND_MAX);
  assign iss_acc_s  = iss_valid && iss_ready && (iss_rd != X0);
  assign wb_live_s  = wb_valid && (wb_rd != X0);
  assign wb_under_s = wb_live_s && (pend_r[wb_rd] == PEND_ZERO);
  assign wb_err     = wb_err_r;

  // Next pending count per register; an issue and write-back to the same register cancel out.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_nxt_s[r] = pend_r[r];
      if (r == 0) begin
        pend_nxt_s[r] = PEND_ZERO;
      end else if (iss_acc_s && (iss_rd == AW'(r)) && !(wb_live_s && (wb_rd == AW'(r)))) begin
        pend_nxt_s[r] = pend_r[r] + PEND_ONE;
      end else if (wb_live_s && (wb_rd == AW'(r)) && !(iss_acc_s && (iss_rd == AW'(r)))
                   && (pend_r[r] != PEND_ZERO)) begin
        pend_nxt_s[r] = pend_r[r] - PEND_ONE;
      end else begin
        pend_nxt_s[r] = pend_r[r];
      end
    end
  end

  // Register storage, scoreboard counters and the sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= DZERO;
        pend_r[r] <= PEND_ZERO;
      end
      wb_err_r <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_r[r] <= pend_nxt_s[r];
      end
      if (wb_live_s) begin
        regs_r[wb_rd] <= wb_data;
      end
      if (wb_under_s) begin
        wb_err_r <= 1'b1;
      end
    end
  end

  // Combinational read ports; x0 always reads zero and is never busy.
  always_comb begin
    rd_data = {(NUM_RD*XLEN){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_addr[i*AW +: AW] == X0) begin
        rd_data[i*XLEN +: XLEN] = DZERO;
        rd_busy[i]              = 1'b0;
`ifdef REGFILE_BYPASS_EN
      end else if (rst_n && wb_live_s && (wb_rd == rd_addr[i*AW +: AW])) begin
        // Forwarded data reports the busy state the register will have after this edge.
        rd_data[i*XLEN +: XLEN] = wb_data;
        rd_busy[i]              = (pend_nxt_s[wb_rd] != PEND_ZERO);
`endif
      end else begin
        rd_data[i*XLEN +: XLEN] = regs_r[rd_addr[i*AW +: AW]];
        rd_busy[i]              = (pend_r[rd_addr[i*AW +: AW]] != PEND_ZERO);
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a vector table plus hand-written
// sequences for write-through bypass and mid-run asynchronous reset.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_scoreboard #(
    .XLEN(32), .NREGS(32), .AW(5), .NUM_RD(2), .PEND_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [4:0]  ir;
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        rdy;
    logic        err;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic iv, input logic [4:0] ir, input logic wv,
                              input logic [4:0] wr, input logic [31:0] wd,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] busy, input logic rdy, input logic err);
    vec_t v;
    v.iv = iv; v.ir = ir; v.wv = wv; v.wr = wr; v.wd = wd;
    v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1;
    v.busy = busy; v.rdy = rdy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ir, input logic wv,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    iss_valid = iv; iss_rd = ir; wb_valid = wv; wb_rd = wr; wb_data = wd;
    rd_addr = {ra1, ra0};
  endtask

  task automatic chk_all(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] busy, input logic rdy, input logic err);
    chk({tag, " rd_data0"}, rd_data[31:0], d0);
    chk({tag, " rd_data1"}, rd_data[63:32], d1);
    chk({tag, " rd_busy"}, {30'd0, rd_busy}, {30'd0, busy});
    chk({tag, " iss_ready"}, {31'd0, iss_ready}, {31'd0, rdy});
    chk({tag, " wb_err"}, {31'd0, wb_err}, {31'd0, err});
  endtask

  initial begin
    // Rows are applied one per cycle; expected outputs are the pre-edge view.
    tbl[0]  = mk(1'b0, 5'd5,  1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h0,        32'h0,        2'b00, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'h0,        32'h0,        2'b01, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 5'd7,  1'b1, 5'd5,  32'hDEADBEEF, 5'd7,  5'd1,  32'h0,        32'h0,        2'b01, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 2'b01, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h0,        32'h0,        2'b01, 1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h0,        32'h0,        2'b01, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 5'd7,  1'b1, 5'd7,  32'h1,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 5'd7,  1'b1, 5'd7,  32'h2,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 5'd7,  1'b1, 5'd7,  32'h3,        5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 5'd7,  1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h3,        32'h0,        2'b00, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h3,        2'b00, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 5'd9,  1'b1, 5'd9,  32'h55,       5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 5'd9,  1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  32'h55,       32'h0,        2'b01, 1'b1, 1'b0);
    tbl[17] = mk(1'b1, 5'd10, 1'b1, 5'd9,  32'h66,       5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd9,  5'd10, 32'h66,       32'h0,        2'b10, 1'b1, 1'b0);
    tbl[19] = mk(1'b0, 5'd0,  1'b1, 5'd3,  32'hAB,       5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 1'b0);
    tbl[20] = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'hAB,       32'h0,        2'b00, 1'b1, 1'b1);
    tbl[21] = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 1'b1);

    rst_n = 1'b0;
    drive(1'b0, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    #1;
    chk_all("reset", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].iv, tbl[k].ir, tbl[k].wv, tbl[k].wr, tbl[k].wd, tbl[k].ra0, tbl[k].ra1);
      #1;
      chk_all($sformatf("vec%0d", k), tbl[k].d0, tbl[k].d1, tbl[k].busy, tbl[k].rdy, tbl[k].err);
      @(negedge clk);
    end

    // Bypass: x4 has one pending write, x10 still has one from the table.
    drive(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd4, 1'b1, 5'd4, 32'h1234, 5'd4, 5'd10);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk_all("bypass same", 32'h1234, 32'h0, 2'b10, 1'b1, 1'b1);
`else
    chk_all("bypass same", 32'h0, 32'h0, 2'b11, 1'b1, 1'b1);
`endif
    @(negedge clk);
    drive(1'b0, 5'd4, 1'b0, 5'd0, 32'h0, 5'd4, 5'd10);
    #1;
    chk_all("bypass next", 32'h1234, 32'h0, 2'b10, 1'b1, 1'b1);
    @(negedge clk);

    // Mid-cycle asynchronous reset with x5 written and reserved.
    drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    chk_all("pre reset", 32'hDEADBEEF, 32'h0, 2'b01, 1'b1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("async reset", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    chk_all("post reset", 32'h0, 32'h0, 2'b01, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
